uart_rx_v_2: RTL and testbench
==============================

UART_RX_V_2 -- requirements
Module: uart_rx_v_2

Interface
REQ-001 Parameter Rx_CLKRATE, default 1_000_000, clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate.
REQ-003 Parameter WORD_LENGTH, default 8, data bits per frame.
REQ-004 Derived: BAUD_COUNTER_MAX = Rx_CLKRATE/BAUD (integer division, 104 at defaults); HALF_BIT = BAUD_COUNTER_MAX/2 (52).
REQ-005 clk  input  1  single system clock; all logic on posedge clk.
REQ-006 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-007 UART_Rx_IN  input  1  asynchronous serial line, idle high.
REQ-008 Rx_DATA  output  WORD_LENGTH  last correctly framed word, LSB first on line.
REQ-009 Rx_VALID  output  1  one-cycle pulse when Rx_DATA is updated.
REQ-010 Rx_FRAME_ERR  output  1  one-cycle pulse when the stop bit samples low.
REQ-011 UART_Rx_BUSY  output  1  high in any state other than IDLE.

Function
REQ-012 UART_Rx_IN SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rx_s); latency is 2 cycles.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-014 IDLE: a 1->0 transition on rx_s SHALL move to START and clear the baud counter.
REQ-015 START: at count HALF_BIT-1, rx_s=0 -> DATA with counter cleared; rx_s=1 -> IDLE (glitch reject), no output pulse.
REQ-016 DATA: every BAUD_COUNTER_MAX cycles, sample rx_s into shift register bit index 0..WORD_LENGTH-1 (LSB first); after bit WORD_LENGTH-1 -> STOP.
REQ-017 Bit counter width SHALL be $clog2(WORD_LENGTH+1); baud counter width $clog2(BAUD_COUNTER_MAX); counter wraps to 0 at BAUD_COUNTER_MAX-1.
REQ-018 STOP: BAUD_COUNTER_MAX cycles after last data sample, sample rx_s; 1 -> load Rx_DATA, pulse Rx_VALID next cycle, -> IDLE; 0 -> pulse Rx_FRAME_ERR, Rx_DATA unchanged, -> WAIT_IDLE.
REQ-019 WAIT_IDLE: remain until rx_s=1, then -> IDLE; a held-low line (break) SHALL produce exactly one Rx_FRAME_ERR.
REQ-020 Rx_VALID and Rx_FRAME_ERR SHALL never assert in the same cycle and SHALL each be exactly one cycle wide.
REQ-021 A new start edge SHALL be detected from the first IDLE cycle after STOP, allowing back-to-back frames with one stop bit.
REQ-022 No backpressure: Rx_DATA holds until the next valid frame; an unread word is overwritten.

Reset
REQ-023 When rst=1: state IDLE, synchronizer flops and edge-detect register = 1, counters = 0, shift register = 0.
REQ-024 Reset outputs: Rx_DATA=0, Rx_VALID=0, Rx_FRAME_ERR=0, UART_Rx_BUSY=0.
REQ-025 rst asserted mid-frame SHALL abort the frame with no pulse; reception resumes on the next falling edge after rst deasserts.

Verification
REQ-026 Frame 0x56 at 104 cycles/bit, stop=1 -> Rx_VALID single pulse, Rx_DATA=0x56, Rx_FRAME_ERR stays 0, UART_Rx_BUSY low after STOP.
REQ-027 Low glitch of 20 cycles on idle line -> UART_Rx_BUSY high ~50 cycles then low; no Rx_VALID, no Rx_FRAME_ERR, Rx_DATA unchanged.
REQ-028 After 0x56, frame 0xA5 with stop=0 -> Rx_FRAME_ERR one pulse, Rx_DATA stays 0x56; line held low 500 further cycles -> no second pulse.
REQ-029 Back-to-back 0xA5 then 0x3C, no idle gap -> two Rx_VALID pulses ~1040 cycles apart, Rx_DATA=0xA5 then 0x3C.
REQ-030 rst pulsed for 1 cycle during data bit 4 of 0xFF -> no pulse, all outputs 0; next frame 0x12 -> Rx_DATA=0x12.
REQ-031 Loopback from UART_Tx_v_2 (same Rx_CLKRATE/BAUD) sending 0x56 four times -> four Rx_VALID pulses, each with Rx_DATA=0x56.

Source files
------------

// File: rtl/uart_rx_v_2_if.sv
// Serial receive port bundle: line input plus received word and status pulses.
interface uart_rx_v_2_if #(
    parameter int WORD_LENGTH = 8
);
    logic                   UART_Rx_IN;
    logic [WORD_LENGTH-1:0] Rx_DATA;
    logic                   Rx_VALID;
    logic                   Rx_FRAME_ERR;
    logic                   UART_Rx_BUSY;

    modport slave (
        input  UART_Rx_IN,
        output Rx_DATA,
        output Rx_VALID,
        output Rx_FRAME_ERR,
        output UART_Rx_BUSY
    );

    modport master (
        output UART_Rx_IN,
        input  Rx_DATA,
        input  Rx_VALID,
        input  Rx_FRAME_ERR,
        input  UART_Rx_BUSY
    );
endinterface

// File: rtl/uart_rx_v_2.sv
// UART receiver: 2-flop line synchronizer, mid-bit sampling FSM, one-cycle
// valid / frame-error pulses, Rx_DATA held until the next good frame.
module uart_rx_v_2 #(
    parameter int Rx_CLKRATE  = 1_000_000,
    parameter int BAUD        = 9600,
    parameter int WORD_LENGTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    uart_rx_v_2_if.slave bus
);
    localparam int BAUD_COUNTER_MAX = Rx_CLKRATE / BAUD;
    localparam int HALF_BIT         = BAUD_COUNTER_MAX / 2;
    localparam int CNT_W            = $clog2(BAUD_COUNTER_MAX);
    localparam int BIT_W            = $clog2(WORD_LENGTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_COUNTER_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_LENGTH - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_IDLE = 3'd4;

    logic                   sync1_q, sync2_q, prev_q;
    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [WORD_LENGTH-1:0] shift_q, shift_d;
    logic [WORD_LENGTH-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   rx_s;
    logic                   baud_tick;

    assign rx_s      = sync2_q;
    assign baud_tick = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx_s) begin
                    state_d = START;
                end
            end
            // Re-check the start bit at its centre to reject short glitches.
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    shift_d[WORD_LENGTH-1] = rx_s;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            // A held-low line (break) parks here so it reports only once.
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= bus.UART_Rx_IN;
            sync2_q <= sync1_q;
            prev_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign bus.Rx_DATA      = data_q;
    assign bus.Rx_VALID     = valid_q;
    assign bus.Rx_FRAME_ERR = ferr_q;
    assign bus.UART_Rx_BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_v_2.sv
// Bench for uart_rx_v_2: table of frames, hand-written corner sequences and
// random frames checked against an event-level reference model.
module tb_uart_rx_v_2;
    localparam int CLKRATE = 1_000_000;
    localparam int BAUDR   = 9600;
    localparam int WL      = 8;
    localparam int BITC    = CLKRATE / BAUDR;
    localparam int LAT_LO  = 9 * BITC + BITC / 2;
    localparam int LAT_HI  = LAT_LO + 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_v_2_if #(.WORD_LENGTH(WL)) bus();

    uart_rx_v_2 #(
        .Rx_CLKRATE (CLKRATE),
        .BAUD       (BAUDR),
        .WORD_LENGTH(WL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit          is_err;
        logic [7:0]  data;
        int          cyc;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        bit         stopb;
        bit         exp_valid;
        bit         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    ev_t  evq[$];
    ev_t  expq[$];
    logic prev_v = 1'b0;
    logic prev_e = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.Rx_VALID === 1'b1) begin
            evq.push_back('{1'b0, bus.Rx_DATA, cyc});
            chk("valid_width", {31'd0, prev_v}, 32'd0);
            chk("valid_ferr_exclusive", {31'd0, bus.Rx_FRAME_ERR}, 32'd0);
        end
        if (bus.Rx_FRAME_ERR === 1'b1) begin
            evq.push_back('{1'b1, 8'h00, cyc});
            chk("ferr_width", {31'd0, prev_e}, 32'd0);
        end
        prev_v = bus.Rx_VALID;
        prev_e = bus.Rx_FRAME_ERR;
    end

    task automatic drive(input logic v, input int n);
        bus.UART_Rx_IN = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stopb);
        drive(1'b0, BITC);
        for (int i = 0; i < WL; i++) drive(d[i], BITC);
        drive(stopb, BITC);
    endtask

    // Reference model: a frame yields a valid event carrying its data when the
    // stop bit is high, otherwise a frame-error event.
    task automatic expect_frame(input logic [7:0] d, input bit stopb, input int start);
        expq.push_back('{!stopb, stopb ? d : 8'h00, start});
    endtask

    task automatic check_events(input string name);
        int lat;
        chk({name, "_count"}, evq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < evq.size(); i++) begin
            chk({name, "_kind"}, {31'd0, evq[i].is_err}, {31'd0, expq[i].is_err});
            if (!expq[i].is_err) chk({name, "_data"}, evq[i].data, expq[i].data);
            lat = evq[i].cyc - expq[i].cyc;
            chk({name, "_latency_in_window"}, (lat >= LAT_LO && lat <= LAT_HI), 1);
        end
        evq.delete();
        expq.delete();
    endtask

    vec_t       tbl[6];
    int         start, start2;
    logic [7:0] last_good;
    logic [7:0] rd;
    bit         rs;
    int         gap;

    initial begin
        tbl[0] = '{8'h56, 1'b1, 1'b1, 1'b0, 8'h56};
        tbl[1] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'h56};
        tbl[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[3] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF};
        tbl[4] = '{8'h81, 1'b0, 1'b0, 1'b1, 8'hFF};
        tbl[5] = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C};

        rst = 1'b1;
        bus.UART_Rx_IN = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_data", bus.Rx_DATA, 8'h00);
        chk("reset_valid", bus.Rx_VALID, 0);
        chk("reset_ferr", bus.Rx_FRAME_ERR, 0);
        chk("reset_busy", bus.UART_Rx_BUSY, 0);
        rst = 1'b0;
        drive(1'b1, 10);

        for (int i = 0; i < 6; i++) begin
            start = cyc;
            send_frame(tbl[i].data, tbl[i].stopb);
            drive(1'b1, 20);
            if (tbl[i].exp_valid || tbl[i].exp_ferr)
                expq.push_back('{tbl[i].exp_ferr, tbl[i].exp_valid ? tbl[i].data : 8'h00, start});
            check_events("table");
            chk("table_rx_data", bus.Rx_DATA, tbl[i].exp_data);
            chk("table_busy_idle", bus.UART_Rx_BUSY, 0);
        end

        // Short low glitch on the idle line must be rejected at mid start bit.
        drive(1'b0, 20);
        drive(1'b1, 10);
        chk("glitch_busy_high", bus.UART_Rx_BUSY, 1);
        drive(1'b1, 60);
        chk("glitch_busy_low", bus.UART_Rx_BUSY, 0);
        check_events("glitch");
        chk("glitch_data_kept", bus.Rx_DATA, 8'h3C);

        // Good frame, then a framing error followed by a long break.
        start = cyc;
        send_frame(8'h56, 1'b1);
        expect_frame(8'h56, 1'b1, start);
        drive(1'b1, 20);
        start = cyc;
        send_frame(8'hA5, 1'b0);
        expect_frame(8'hA5, 1'b0, start);
        drive(1'b0, 500);
        chk("break_busy_held", bus.UART_Rx_BUSY, 1);
        drive(1'b1, 10);
        chk("break_busy_released", bus.UART_Rx_BUSY, 0);
        check_events("break");
        chk("break_data_kept", bus.Rx_DATA, 8'h56);

        // Back-to-back frames with a single stop bit and no idle gap.
        start = cyc;
        send_frame(8'hA5, 1'b1);
        start2 = cyc;
        send_frame(8'h3C, 1'b1);
        drive(1'b1, 20);
        expect_frame(8'hA5, 1'b1, start);
        expect_frame(8'h3C, 1'b1, start2);
        if (evq.size() == 2) chk("b2b_spacing", evq[1].cyc - evq[0].cyc, 10 * BITC);
        else chk("b2b_two_events", evq.size(), 2);
        check_events("b2b");
        chk("b2b_final_data", bus.Rx_DATA, 8'h3C);

        // Reset pulse in the middle of data bit 4 of 0xFF aborts the frame.
        drive(1'b0, BITC);
        drive(1'b1, 4 * BITC + BITC / 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 4 * BITC);
        check_events("midreset");
        chk("midreset_data", bus.Rx_DATA, 8'h00);
        chk("midreset_valid", bus.Rx_VALID, 0);
        chk("midreset_ferr", bus.Rx_FRAME_ERR, 0);
        chk("midreset_busy", bus.UART_Rx_BUSY, 0);
        start = cyc;
        send_frame(8'h12, 1'b1);
        expect_frame(8'h12, 1'b1, start);
        drive(1'b1, 20);
        check_events("after_reset");
        chk("after_reset_data", bus.Rx_DATA, 8'h12);

        // Transmitter-style stream: 0x56 four times, one stop bit each.
        for (int i = 0; i < 4; i++) begin
            start = cyc;
            send_frame(8'h56, 1'b1);
            expect_frame(8'h56, 1'b1, start);
        end
        drive(1'b1, 20);
        check_events("loopback");

        // Random frames against the reference model.
        last_good = 8'h56;
        for (int i = 0; i < 16; i++) begin
            rd = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            start = cyc;
            send_frame(rd, rs);
            expect_frame(rd, rs, start);
            if (rs) last_good = rd;
            gap = rs ? $urandom_range(0, 25) : $urandom_range(4, 25);
            if (gap > 0) drive(1'b1, gap);
        end
        drive(1'b1, 20);
        check_events("random");
        chk("random_final_data", bus.Rx_DATA, last_good);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
